// File: rtl/crgu_pkg.sv
// crgu_pkg: types and helpers shared by the clock-reset unit blocks
package crgu_pkg;
    typedef enum logic [2:0] {IDLE, DRAIN, GATE, UPDATE, RELEASE} ctrl_state_e;
    localparam int MIN_DIV = 2;
    function automatic logic is_legal_div(input int d);
        return d >= MIN_DIV;
    endfunction
endpackage

// File: rtl/pclk_div_ctrl_if.sv
// pclk_div_ctrl_if: requester handshake plus divider-side signals of the pclk divider controller
interface pclk_div_ctrl_if #(parameter int DIV_WID = 4);
    logic               cfg_valid;
    logic [DIV_WID-1:0] cfg_div;
    logic               cfg_rst;
    logic               cfg_ready;
    logic               cfg_err;
    logic               cfg_done;
    logic               busy;
    logic               pclken;
    logic [DIV_WID-1:0] div_factor;
    logic               div_en;
    logic               periph_rst_req;
    modport master (
        output cfg_valid, cfg_div, cfg_rst, pclken,
        input  cfg_ready, cfg_err, cfg_done, busy, div_factor, div_en, periph_rst_req
    );
    modport slave (
        input  cfg_valid, cfg_div, cfg_rst, pclken,
        output cfg_ready, cfg_err, cfg_done, busy, div_factor, div_en, periph_rst_req
    );
endinterface

// File: rtl/pclk_div_timer.sv
// pclk_div_timer: loadable down-counter that saturates at zero
module pclk_div_timer #(
    parameter int WID = 5
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_load,
    input  logic           i_en,
    input  logic [WID-1:0] i_val,
    output logic           o_zero
);
    logic [WID-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - WID'(1);
    end
    assign o_zero = r_cnt == '0;
endmodule

// File: rtl/pclk_div_ctrl.sv
// pclk_div_ctrl: accepts divide-ratio requests and switches the pclk divider at a pclk boundary,
// gating the divider and optionally holding the peripheral reset around the switch
module pclk_div_ctrl import crgu_pkg::*; #(
    parameter int DIV_WID  = 4,
    parameter int DEF_DIV  = 2,
    parameter int GATE_CYC = 2,
    parameter int RST_CYC  = 4
) (
    input logic             i_hclk,
    input logic             i_hreset,
    pclk_div_ctrl_if.slave  bus
);
    localparam int TW = DIV_WID + 1;
    localparam logic [TW-1:0] TMO = '1;
    ctrl_state_e        r_state, w_next;
    logic [DIV_WID-1:0] r_pend_div, r_div_factor;
    logic               r_pend_rst, r_seen, r_ready, r_err, r_done, r_busy, r_div_en, r_prst;
    logic               w_accept, w_legal, w_noop, w_start, w_zero, w_load;
    logic [TW-1:0]      w_load_val;
    assign w_accept = bus.cfg_valid && r_ready;
    assign w_legal  = is_legal_div(int'(bus.cfg_div));
    assign w_noop   = bus.cfg_div == r_div_factor && !bus.cfg_rst;
    assign w_start  = w_accept && w_legal && !w_noop;
    pclk_div_timer #(.WID(TW)) u_timer (
        .i_clk  (i_hclk),
        .i_rst  (i_hreset),
        .i_load (w_load),
        .i_en   (r_state != IDLE),
        .i_val  (w_load_val),
        .o_zero (w_zero)
    );
    // One timer serves the DRAIN timeout, the GATE hold and the RELEASE hold; loaded with N-1 to last N cycles.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            IDLE: if (w_start) begin
                w_next     = DRAIN;
                w_load     = 1'b1;
                w_load_val = TMO;
            end
            DRAIN: if (r_seen || w_zero) begin
                w_next     = GATE;
                w_load     = 1'b1;
                w_load_val = TW'(GATE_CYC - 1);
            end
            GATE: if (w_zero) w_next = UPDATE;
            UPDATE: begin
                w_next     = RELEASE;
                w_load     = 1'b1;
                w_load_val = r_pend_rst ? TW'(RST_CYC - 1) : '0;
            end
            RELEASE: if (w_zero) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // pclken is registered so the boundary is acted on one edge after it is seen in DRAIN.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state      <= IDLE;
            r_pend_div   <= '0;
            r_pend_rst   <= 1'b0;
            r_div_factor <= DIV_WID'(DEF_DIV);
            r_seen       <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_div_en     <= 1'b1;
            r_prst       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_pend_div <= bus.cfg_div;
                r_pend_rst <= bus.cfg_rst;
            end
            if (r_state == UPDATE)
                r_div_factor <= r_pend_div;
            r_seen   <= r_state == DRAIN && bus.pclken;
            r_ready  <= w_next == IDLE;
            r_busy   <= w_next != IDLE;
            r_err    <= w_accept && !w_legal;
            r_done   <= (w_accept && w_legal && w_noop) || (r_state == RELEASE && w_zero);
            r_div_en <= !(w_next inside {GATE, UPDATE});
            r_prst   <= r_pend_rst && (w_next inside {GATE, UPDATE, RELEASE});
        end
    end
    assign bus.cfg_ready      = r_ready;
    assign bus.cfg_err        = r_err;
    assign bus.cfg_done       = r_done;
    assign bus.busy           = r_busy;
    assign bus.div_factor     = r_div_factor;
    assign bus.div_en         = r_div_en;
    assign bus.periph_rst_req = r_prst;
endmodule

// File: tb/tb_pclk_div_ctrl.sv
// tb_pclk_div_ctrl: scoreboard bench for the pclk divider controller
module tb_pclk_div_ctrl;
    localparam int DIV_WID  = 4;
    localparam int DEF_DIV  = 2;
    localparam int GATE_CYC = 2;
    localparam int RST_CYC  = 4;
    typedef struct {bit err; int cyc; int fac;} exp_t;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    int                 cyc = 0;
    int                 n_chk = 0;
    int                 n_err = 0;
    int                 n_busy = 0;
    int                 n_en_low = 0;
    int                 n_prst = 0;
    int                 exp_fac = DEF_DIV;
    exp_t               sb[$];
    exp_t               e;
    logic               prev_en = 1'b1;
    logic [DIV_WID-1:0] prev_fac = DIV_WID'(DEF_DIV);
    pclk_div_ctrl_if #(.DIV_WID(DIV_WID)) bus ();
    pclk_div_ctrl #(
        .DIV_WID(DIV_WID), .DEF_DIV(DEF_DIV), .GATE_CYC(GATE_CYC), .RST_CYC(RST_CYC)
    ) dut (
        .i_hclk   (clk),
        .i_hreset (rst),
        .bus      (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d at cyc %0d", tag, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        if (bus.busy) n_busy++;
        if (!bus.div_en) n_en_low++;
        if (bus.periph_rst_req) n_prst++;
        if (bus.div_factor != prev_fac)
            chk("fac_change_on_en_rise", int'({prev_en, bus.div_en}), 1);
        if (bus.cfg_done || bus.cfg_err) begin
            if (sb.size() == 0)
                chk("unexpected_event", 1, 0);
            else begin
                e = sb.pop_front();
                chk("evt_is_err", int'(bus.cfg_err), int'(e.err));
                chk("evt_cycle", cyc, e.cyc);
                chk("evt_factor", int'(bus.div_factor), e.fac);
            end
        end
        prev_en  = bus.div_en;
        prev_fac = bus.div_factor;
    end
    task automatic req(input int div, input bit rst_f, input int k, input bit pulse);
        int acc;
        int lat;
        int n = 0;
        bit legal = div >= 2;
        bit sw = legal && !(div == exp_fac && !rst_f);
        exp_t x;
        @(negedge clk);
        chk("ready_before_req", int'(bus.cfg_ready), 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = DIV_WID'(div);
        bus.cfg_rst   = rst_f;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.cfg_valid = 1'b0;
        n_busy = 0;
        n_en_low = 0;
        n_prst = 0;
        lat = sw ? 1 + k + 1 + GATE_CYC + 1 + (rst_f ? RST_CYC : 1) : 0;
        if (legal) exp_fac = div;
        x.err = !legal;
        x.cyc = acc + lat;
        x.fac = exp_fac;
        sb.push_back(x);
        if (pulse) begin
            repeat (k) begin
                @(posedge clk);
                #1;
            end
            bus.pclken = 1'b1;
            @(posedge clk);
            #1;
            bus.pclken = 1'b0;
        end
        while (!(bus.cfg_done || bus.cfg_err) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_within_bound", int'(n < 200), 1);
        chk("busy_cycles", n_busy, lat);
        chk("div_en_low_cycles", n_en_low, sw ? GATE_CYC + 1 : 0);
        chk("prst_cycles", n_prst, (sw && rst_f) ? GATE_CYC + 1 + RST_CYC : 0);
        chk("factor_after", int'(bus.div_factor), exp_fac);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1);
    end
    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        bus.cfg_rst   = 1'b0;
        bus.pclken    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_div_factor", int'(bus.div_factor), DEF_DIV);
        chk("rst_div_en", int'(bus.div_en), 1);
        chk("rst_ready", int'(bus.cfg_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_prst", int'(bus.periph_rst_req), 0);
        req(1, 1'b0, 0, 1'b0);
        req(0, 1'b0, 0, 1'b0);
        req(2, 1'b0, 0, 1'b0);
        req(4, 1'b0, 3, 1'b1);
        req(6, 1'b1, 0, 1'b1);
        req(8, 1'b0, 30, 1'b0);
        req(8, 1'b1, 2, 1'b1);
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 4'd10;
        bus.cfg_rst   = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_div = 4'd12;
        bus.pclken  = 1'b1;
        @(posedge clk);
        #1;
        bus.pclken = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_gate_div_en", int'(bus.div_en), 0);
        chk("mid_gate_ready", int'(bus.cfg_ready), 0);
        chk("mid_gate_prst", int'(bus.periph_rst_req), 1);
        bus.cfg_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_fac = DEF_DIV;
        chk("abort_div_en", int'(bus.div_en), 1);
        chk("abort_factor", int'(bus.div_factor), DEF_DIV);
        chk("abort_prst", int'(bus.periph_rst_req), 0);
        chk("abort_busy", int'(bus.busy), 0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_settled_busy", int'(bus.busy), 0);
        chk("abort_settled_factor", int'(bus.div_factor), DEF_DIV);
        req(3, 1'b0, 1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
